fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch controller that sequences the combinational text memory of the single-cycle RISC-V core. Holds the program counter, drives the memory's word address, and captures each fetched word into a one-entry output register with a valid/ready handshake toward decode. Handles branch/jump redirects, consumer stalls, halting on an all-zero word, and faults on misaligned or out-of-range PCs.

## Interface
- DATA_WIDTH, 32, instruction width (matches text memory)
- ADDR_WIDTH, 8, text-memory word-address width
- RESET_PC, 32'h0000_0000, byte PC after reset; must be word-aligned and in range
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- mem_addr  out  ADDR_WIDTH  word address to text memory, = pc[ADDR_WIDTH+1:2]
- mem_data  in  DATA_WIDTH  word returned combinationally by text memory
- redirect_valid  in  1  load redirect_pc this cycle (taken branch/jump)
- redirect_pc  in  32  byte target address
- inst_valid  out  1  inst/inst_pc hold a fetched instruction
- inst_ready  in  1  consumer accepts inst this cycle
- inst  out  DATA_WIDTH  fetched instruction
- inst_pc  out  32  byte PC of inst
- halted  out  1  sequencer in HALT
- fault  out  1  sequencer in FAULT
- fault_pc  out  32  offending byte PC

## Operation
- States: RUN, HALT, FAULT. Reset → RUN, pc = RESET_PC.
- Capture condition (RUN only): take = !inst_valid || inst_ready.
- RUN, no redirect, take, pc in range, mem_data != 0: inst ← mem_data, inst_pc ← pc, inst_valid ← 1, pc ← pc + 4.
- RUN, take, mem_data == 32'h0 (halt word): no capture; inst_valid ← 0 if the handshake fired, else unchanged; → HALT; pc holds.
- In range: pc[31:ADDR_WIDTH+2] == 0. Out-of-range pc with take → FAULT, fault_pc ← pc, no capture.
- pc increment is 32-bit modular; stepping past the last word (e.g. 0x3FC → 0x400 at ADDR_WIDTH=8) produces an out-of-range fault on the next capture attempt, never an address wrap.
- !take (stall): pc, inst, inst_pc, inst_valid, mem_addr all held.
- Redirect (any state) has priority over capture, halt and fault detection:
  - if inst_valid && inst_ready the current handshake completes normally;
  - inst_valid ← 0 (the pending instruction is squashed if not accepted);
  - redirect_pc[1:0] != 0 or out of range → FAULT, fault_pc ← redirect_pc;
  - otherwise pc ← redirect_pc, → RUN, fault/halted cleared.
- HALT and FAULT: no fetch; an already-captured inst stays valid until accepted; exit only by a valid redirect or rst.
- fault_pc holds until the next entry into FAULT or rst.

## Timing
- Reset values: inst_valid 0, inst 0, inst_pc 0, halted 0, fault 0, fault_pc 0, mem_addr = RESET_PC[ADDR_WIDTH+1:2].
- mem_addr is a combinational decode of the pc register only (no input-to-output path).
- Latency: first inst_valid = 1 in the cycle after rst deasserts. Redirect in cycle N → inst_valid 0 in N+1, target instruction valid in N+2.
- Throughput: one instruction per cycle while inst_ready stays high.
- halted and fault assert in the cycle after the detecting edge and are mutually exclusive.
- rst asserted mid-operation overrides everything on that edge, including redirect.

## Structure
- Shared package fetch_pkg: state enum {RUN, HALT, FAULT}, HALT_WORD = 32'h0, PC_WIDTH = 32, PC_STEP = 4.
- Single module; the out-of-range/misalignment check is a local function, not a sub-module. The text memory is instantiated by the parent, not inside this block.

## Test plan
- Reset, inst_ready = 1, memory words 0..3 = 0x00052503, 0x0085a583, 0x00a58633, 0x00c2a423 -> four consecutive valid cycles with inst_pc 0x0, 0x4, 0x8, 0xC and matching inst.
- inst_ready low for 3 cycles while inst_pc = 0x4 -> inst, inst_pc and mem_addr held; the same word is accepted once ready returns, then 0x8 follows.
- redirect_pc = 0x30 while inst_pc = 0x10 is pending and not accepted -> 0x10 squashed, next valid is inst_pc 0x30, inst = word 12.
- Fetch reaches an all-zero word at 0x20 -> halted = 1, no instruction emitted for 0x20; redirect to 0x0 -> halted = 0, fetch restarts at 0x0.
- redirect_pc = 0x6 -> fault = 1, fault_pc = 0x6; redirect_pc = 0x400 (ADDR_WIDTH = 8) -> fault, fault_pc = 0x400; sequential run to 0x3FC then the step to 0x400 -> fault_pc = 0x400.
- rst pulsed during a stall with redirect_valid high -> all outputs at their reset values, restart from RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Imported by fetch_sequencer and by anything that decodes its state.
package fetch_pkg;

    typedef enum logic [1:0] {
        StRun,
        StHalt,
        StFault
    } fetch_state_e;

    localparam int unsigned            PC_WIDTH  = 32;
    localparam logic [31:0]            HALT_WORD = 32'h0000_0000;
    localparam logic [PC_WIDTH-1:0]    PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, addresses the combinational text memory and
// hands fetched words to decode through a one-entry valid/ready output register.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          ADDR_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0]  RESET_PC   = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_data,
    input  logic                    redirect_valid,
    input  logic [PC_WIDTH-1:0]     redirect_pc,
    output logic                    inst_valid,
    input  logic                    inst_ready,
    output logic [DATA_WIDTH-1:0]   inst,
    output logic [PC_WIDTH-1:0]     inst_pc,
    output logic                    halted,
    output logic                    fault,
    output logic [PC_WIDTH-1:0]     fault_pc
);

    fetch_state_e            state_q, state_d;
    logic [PC_WIDTH-1:0]     pc_q, pc_d;
    logic [DATA_WIDTH-1:0]   inst_q, inst_d;
    logic [PC_WIDTH-1:0]     inst_pc_q, inst_pc_d;
    logic                    inst_valid_q, inst_valid_d;
    logic [PC_WIDTH-1:0]     fault_pc_q, fault_pc_d;
    logic                    take;

    // Word-aligned and inside the text memory; the PC never wraps into low addresses.
    function automatic logic pc_ok(input logic [PC_WIDTH-1:0] pc);
        return (pc[1:0] == 2'b00) && ((pc >> (ADDR_WIDTH + 2)) == '0);
    endfunction

    assign take = !inst_valid_q || inst_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            fault_pc_q   <= '0;
        end else begin
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            fault_pc_q   <= fault_pc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        fault_pc_d   = fault_pc_q;

        if (redirect_valid) begin
            // Squashes any pending instruction; an accepted one has already left.
            inst_valid_d = 1'b0;
            if (pc_ok(redirect_pc)) begin
                pc_d    = redirect_pc;
                state_d = StRun;
            end else begin
                fault_pc_d = redirect_pc;
                state_d    = StFault;
            end
        end else begin
            unique case (state_q)
                StRun: begin
                    if (take) begin
                        if (!pc_ok(pc_q)) begin
                            inst_valid_d = 1'b0;
                            fault_pc_d   = pc_q;
                            state_d      = StFault;
                        end else if (mem_data == DATA_WIDTH'(HALT_WORD)) begin
                            inst_valid_d = 1'b0;
                            state_d      = StHalt;
                        end else begin
                            inst_d       = mem_data;
                            inst_pc_d    = pc_q;
                            inst_valid_d = 1'b1;
                            pc_d         = pc_q + PC_STEP;
                        end
                    end
                end
                StHalt, StFault: begin
                    if (inst_valid_q && inst_ready) begin
                        inst_valid_d = 1'b0;
                    end
                end
                default: state_d = StFault;
            endcase
        end
    end

    always_comb begin
        mem_addr   = pc_q[ADDR_WIDTH+1:2];
        inst_valid = inst_valid_q;
        inst       = inst_q;
        inst_pc    = inst_pc_q;
        halted     = (state_q == StHalt);
        fault      = (state_q == StFault);
        fault_pc   = fault_pc_q;
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural model of the fetch rules.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  mem_addr;
    logic [31:0] mem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        halted;
    logic        fault;
    logic [31:0] fault_pc;

    logic [31:0] mem [256];

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model state
    logic [31:0] m_pc, m_inst, m_inst_pc, m_fpc;
    logic        m_valid, m_halted, m_fault;

    always #5 clk = ~clk;

    assign mem_data = mem[mem_addr];

    fetch_sequencer #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (8),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .halted         (halted),
        .fault          (fault),
        .fault_pc       (fault_pc)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic target_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'h400);
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_update();
        logic fired, can_take;
        fired    = m_valid && inst_ready;
        can_take = !m_valid || inst_ready;
        if (rst) begin
            m_pc = 0; m_inst = 0; m_inst_pc = 0; m_fpc = 0;
            m_valid = 0; m_halted = 0; m_fault = 0;
        end else if (redirect_valid) begin
            m_valid = 0;
            if (target_bad(redirect_pc)) begin
                m_fault = 1; m_halted = 0; m_fpc = redirect_pc;
            end else begin
                m_pc = redirect_pc; m_fault = 0; m_halted = 0;
            end
        end else if (!m_halted && !m_fault) begin
            if (can_take) begin
                if (m_pc >= 32'h400) begin
                    m_fault = 1; m_fpc = m_pc; m_valid = 0;
                end else if (mem[m_pc / 4] == 32'h0) begin
                    m_halted = 1; m_valid = 0;
                end else begin
                    m_inst = mem[m_pc / 4]; m_inst_pc = m_pc; m_valid = 1; m_pc = m_pc + 4;
                end
            end
        end else if (fired) begin
            m_valid = 0;
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check_eq("inst_valid", 32'(inst_valid), 32'(m_valid));
        check_eq("inst", inst, m_inst);
        check_eq("inst_pc", inst_pc, m_inst_pc);
        check_eq("halted", 32'(halted), 32'(m_halted));
        check_eq("fault", 32'(fault), 32'(m_fault));
        check_eq("fault_pc", fault_pc, m_fpc);
        check_eq("mem_addr", 32'(mem_addr), (m_pc / 4) % 256);
    endtask

    task automatic fill_mem_nonzero();
        for (int i = 0; i < 256; i++) mem[i] = $urandom | 32'h1;
        mem[0] = 32'h0005_2503;
        mem[1] = 32'h0085_a583;
        mem[2] = 32'h00a5_8633;
        mem[3] = 32'h00c2_a423;
    endtask

    task automatic do_reset();
        rst = 1; redirect_valid = 0; redirect_pc = 0;
        step();
        rst = 0;
    endtask

    initial begin
        rst = 1; redirect_valid = 0; redirect_pc = 0; inst_ready = 1;
        m_pc = 0; m_inst = 0; m_inst_pc = 0; m_fpc = 0;
        m_valid = 0; m_halted = 0; m_fault = 0;
        fill_mem_nonzero();
        #2;

        // Reset state and four back-to-back fetches
        do_reset();
        check_eq("rst_valid", 32'(inst_valid), 32'd0);
        check_eq("rst_addr", 32'(mem_addr), 32'd0);
        inst_ready = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("seq_pc", inst_pc, 32'(i * 4));
        end
        check_eq("seq_inst3", inst, 32'h00c2_a423);

        // Stall for three cycles while 0x4 is held
        do_reset();
        step();
        step();
        inst_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("stall_pc", inst_pc, 32'h4);
        end
        inst_ready = 1;
        step();
        check_eq("resume_pc", inst_pc, 32'h8);
        step();

        // Redirect squashes an unaccepted 0x10
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (m_valid && m_inst_pc == 32'h10) break;
            step();
        end
        inst_ready = 0; redirect_valid = 1; redirect_pc = 32'h30;
        step();
        check_eq("squash_valid", 32'(inst_valid), 32'd0);
        redirect_valid = 0; inst_ready = 1;
        step();
        check_eq("redir_pc", inst_pc, 32'h30);
        check_eq("redir_inst", inst, mem[12]);
        step();

        // Halt on an all-zero word at 0x20, then restart
        mem[8] = 32'h0;
        do_reset();
        for (int i = 0; i < 11; i++) step();
        check_eq("halt_flag", 32'(halted), 32'd1);
        redirect_valid = 1; redirect_pc = 32'h0;
        step();
        check_eq("halt_clear", 32'(halted), 32'd0);
        redirect_valid = 0;
        step();
        check_eq("restart_pc", inst_pc, 32'h0);
        step();

        // Misaligned, out-of-range redirect and running off the end
        fill_mem_nonzero();
        redirect_valid = 1; redirect_pc = 32'h6;
        step();
        check_eq("mis_fpc", fault_pc, 32'h6);
        redirect_pc = 32'h400;
        step();
        check_eq("oor_fpc", fault_pc, 32'h400);
        redirect_pc = 32'h3F0;
        step();
        redirect_valid = 0;
        for (int i = 0; i < 8; i++) step();
        check_eq("end_fault", 32'(fault), 32'd1);
        check_eq("end_fpc", fault_pc, 32'h400);

        // Reset during a stall with redirect asserted
        do_reset();
        step();
        inst_ready = 0; step(); step();
        rst = 1; redirect_valid = 1; redirect_pc = 32'h40;
        step();
        check_eq("rst_mid_valid", 32'(inst_valid), 32'd0);
        rst = 0; redirect_valid = 0; inst_ready = 1;
        step();
        check_eq("rst_mid_pc", inst_pc, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 15) == 0) ? 32'h0 : ($urandom | 32'h1);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst        = ($urandom_range(0, 199) == 0);
            inst_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 4) == 0) redirect_pc = $urandom;
            else if ($urandom_range(0, 4) == 0) redirect_pc = 32'h3E0 + 4 * $urandom_range(0, 7);
            else redirect_pc = 4 * $urandom_range(0, 255);
            step();
        end
        rst = 0; redirect_valid = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
